// File: rtl/reg_write_arbiter_pkg.sv
// reg_map_pkg: register map, bus widths and arbiter state encoding for reg_write_arbiter.
//   Shared with the SPI decode path, which uses the same address constants.
//   ADDR_W/DATA_W: bus widths; NUM_REGS: implemented registers (addresses >= NUM_REGS are invalid).
package reg_map_pkg;
  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 8;
  localparam int NUM_REGS       = 5;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;
  typedef enum logic {ST_IDLE, ST_WRITE} arb_state_e;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: one requester's register-write channel.
//   req_valid/req_addr/req_data: driven by the requester, held stable until accepted.
//   req_ready: 1-cycle accept pulse from the arbiter.
//   master = requester side, slave = arbiter side.
interface reg_write_arbiter_if;
  import reg_map_pkg::*;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/reg_write_arbiter_rr.sv
// rr_arbiter2: two-request round-robin arbiter with a last-grant pointer.
//   clk, rst: clock and synchronous active-high reset (reset gives SPI priority).
//   req[1:0]: requests (bit 0 = SPI, bit 1 = sequencer).
//   grant_en: pointer advances only when a grant is actually taken.
//   gnt[1:0]: one-hot grant (combinational).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);
  // last_seq=1 means the sequencer won last, so a tie goes to SPI.
  logic last_seq;
  always_comb gnt = (req == 2'b11) ? (last_seq ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (rst) last_seq <= 1'b1;
    else if (grant_en && |req) last_seq <= gnt[1];
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: owns the five control registers and arbitrates writes from SPI and the sequencer.
//   clk, rst: clock and synchronous active-high reset.
//   spi, seq: requester write channels (valid/addr/data in, 1-cycle ready pulse out).
//   pwm_period_end: PWM wrap pulse, commits a pending duty write when shadowing is built in.
//   en_reg_*, pwm_duty_cycle: register contents at addresses 0..4.
//   wr_err: pulses with ready when the accepted address is invalid.
//   busy: high while a write is in progress.
//   Build macro ARB_DUTY_SHADOW_EN: duty writes are held in a shadow until pwm_period_end.
module reg_write_arbiter
  import reg_map_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  reg_write_arbiter_if.slave       spi,
  reg_write_arbiter_if.slave       seq,
  input  logic                     pwm_period_end,
  output logic [DATA_W-1:0]        en_reg_out_7_0,
  output logic [DATA_W-1:0]        en_reg_out_15_8,
  output logic [DATA_W-1:0]        en_reg_pwm_7_0,
  output logic [DATA_W-1:0]        en_reg_pwm_15_8,
  output logic [DATA_W-1:0]        pwm_duty_cycle,
  output logic                     wr_err,
  output logic                     busy
);
`ifdef ARB_DUTY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
  logic [DATA_W-1:0] duty_shadow;
  logic              duty_pend;
`else
  localparam bit SHADOW = 1'b0;
  logic unused_period_end;
  assign unused_period_end = pwm_period_end;
`endif
  arb_state_e        state, next;
  logic              win_seq;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      ({seq.req_valid, spi.req_valid}),
    .grant_en (state == ST_IDLE),
    .gnt      (gnt)
  );
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= next;
  always_comb begin
    next  = (state == ST_IDLE && (spi.req_valid || seq.req_valid)) ? ST_WRITE : ST_IDLE;
    busy  = state == ST_WRITE;
    wr_ok = busy && wa < ADDR_W'(NUM_REGS);
    wr_err = busy && !(wa < ADDR_W'(NUM_REGS));
  end
  assign spi.req_ready = busy && !win_seq;
  assign seq.req_ready = busy && win_seq;
  always_ff @(posedge clk)
    if (rst) begin
      win_seq <= 1'b0;
      wa <= '0;
      wd <= '0;
      regs <= '{default: '0};
`ifdef ARB_DUTY_SHADOW_EN
      duty_shadow <= '0;
      duty_pend <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE) begin
        win_seq <= gnt[1];
        wa <= gnt[0] ? spi.req_addr : seq.req_addr;
        wd <= gnt[0] ? spi.req_data : seq.req_data;
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_ok && wa == ADDR_W'(i) && !(SHADOW && i == ADDR_DUTY)) regs[i] <= wd;
`ifdef ARB_DUTY_SHADOW_EN
      // Commit uses the old shadow; a same-edge duty write then re-arms the shadow.
      if (pwm_period_end && duty_pend) begin
        regs[ADDR_DUTY] <= duty_shadow;
        duty_pend <= 1'b0;
      end
      if (wr_ok && wa == ADDR_W'(ADDR_DUTY)) begin
        duty_shadow <= wd;
        duty_pend <= 1'b1;
      end
`endif
    end
  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_DUTY];
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed checks of reset, single writes, round-robin, invalid address, duty shadow and mid-write reset.
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_period_end = 1'b0;
  logic [7:0] o_lo, o_hi, p_lo, p_hi, duty;
  logic wr_err, busy;
  int passed = 0, failed = 0, total = 0;
  logic [7:0] m_lo, m_hi, sd, qd;
  logic exp_seq;
  reg_write_arbiter_if spi_if ();
  reg_write_arbiter_if seq_if ();
  reg_write_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_if),
    .seq             (seq_if),
    .pwm_period_end  (pwm_period_end),
    .en_reg_out_7_0  (o_lo),
    .en_reg_out_15_8 (o_hi),
    .en_reg_pwm_7_0  (p_lo),
    .en_reg_pwm_15_8 (p_hi),
    .pwm_duty_cycle  (duty),
    .wr_err          (wr_err),
    .busy            (busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag, input logic [7:0] a, b, c, d, e);
    chk({tag, " out_lo"}, o_lo, a);
    chk({tag, " out_hi"}, o_hi, b);
    chk({tag, " pwm_lo"}, p_lo, c);
    chk({tag, " pwm_hi"}, p_hi, d);
    chk({tag, " duty"}, duty, e);
  endtask
  task automatic spi_write(input logic [3:0] a, input logic [7:0] d);
    spi_if.req_valid = 1'b1;
    spi_if.req_addr = a;
    spi_if.req_data = d;
    tick;
    chk("spi wr ready", {7'b0, spi_if.req_ready}, 8'd1);
    tick;
    spi_if.req_valid = 1'b0;
  endtask
  initial begin
    spi_if.req_valid = 1'b0; spi_if.req_addr = '0; spi_if.req_data = '0;
    seq_if.req_valid = 1'b0; seq_if.req_addr = '0; seq_if.req_data = '0;
    rst = 1'b1;
    tick; tick;
    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset busy", {7'b0, busy}, 8'd0);
    chk("reset spi_ready", {7'b0, spi_if.req_ready}, 8'd0);
    chk("reset seq_ready", {7'b0, seq_if.req_ready}, 8'd0);
    chk("reset wr_err", {7'b0, wr_err}, 8'd0);
    rst = 1'b0;
    tick;
    spi_if.req_valid = 1'b1; spi_if.req_addr = 4'd2; spi_if.req_data = 8'hA5;
    tick;
    chk("single ready", {7'b0, spi_if.req_ready}, 8'd1);
    chk("single seq_ready", {7'b0, seq_if.req_ready}, 8'd0);
    chk("single busy", {7'b0, busy}, 8'd1);
    chk("single pwm_lo early", p_lo, 8'h00);
    tick;
    spi_if.req_valid = 1'b0;
    chk("single ready drop", {7'b0, spi_if.req_ready}, 8'd0);
    chk("single busy drop", {7'b0, busy}, 8'd0);
    chk("single pwm_lo", p_lo, 8'hA5);
    tick;
    chk("single pwm_lo hold", p_lo, 8'hA5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_lo = 8'h00; m_hi = 8'h00; sd = 8'h11; qd = 8'h22;
    spi_if.req_valid = 1'b1; spi_if.req_addr = 4'd0; spi_if.req_data = sd;
    seq_if.req_valid = 1'b1; seq_if.req_addr = 4'd1; seq_if.req_data = qd;
    for (int i = 0; i < 4; i++) begin
      exp_seq = (i % 2) == 1;
      tick;
      chk($sformatf("rr%0d spi_ready", i), {7'b0, spi_if.req_ready}, {7'b0, !exp_seq});
      chk($sformatf("rr%0d seq_ready", i), {7'b0, seq_if.req_ready}, {7'b0, exp_seq});
      tick;
      if (exp_seq) begin
        m_hi = qd; qd = qd + 8'h20; seq_if.req_data = qd;
      end else begin
        m_lo = sd; sd = sd + 8'h20; spi_if.req_data = sd;
      end
      chk($sformatf("rr%0d out_lo", i), o_lo, m_lo);
      chk($sformatf("rr%0d out_hi", i), o_hi, m_hi);
    end
    spi_if.req_valid = 1'b0;
    seq_if.req_valid = 1'b0;
    tick;
    seq_if.req_valid = 1'b1; seq_if.req_addr = 4'd7; seq_if.req_data = 8'hFF;
    tick;
    chk("inv seq_ready", {7'b0, seq_if.req_ready}, 8'd1);
    chk("inv wr_err", {7'b0, wr_err}, 8'd1);
    chk("inv spi_ready", {7'b0, spi_if.req_ready}, 8'd0);
    tick;
    seq_if.req_valid = 1'b0;
    chk("inv wr_err drop", {7'b0, wr_err}, 8'd0);
    chk_regs("inv", 8'h31, 8'h42, 8'h00, 8'h00, 8'h00);
    spi_write(4'd4, 8'h40);
`ifdef ARB_DUTY_SHADOW_EN
    chk("duty first", duty, 8'h00);
`else
    chk("duty first", duty, 8'h40);
`endif
    spi_write(4'd4, 8'h80);
    tick;
`ifdef ARB_DUTY_SHADOW_EN
    chk("duty pending", duty, 8'h00);
`else
    chk("duty second", duty, 8'h80);
`endif
    pwm_period_end = 1'b1;
    tick;
    pwm_period_end = 1'b0;
    chk("duty after period end", duty, 8'h80);
    spi_if.req_valid = 1'b1; spi_if.req_addr = 4'd3; spi_if.req_data = 8'h3C;
    tick;
    chk("midrst busy", {7'b0, busy}, 8'd1);
    rst = 1'b1;
    spi_if.req_valid = 1'b0;
    tick;
    chk("midrst pwm_hi", p_hi, 8'h00);
    chk("midrst busy cleared", {7'b0, busy}, 8'd0);
    chk("midrst ready", {7'b0, spi_if.req_ready}, 8'd0);
    rst = 1'b0;
    tick;
    chk("post rst ready", {7'b0, spi_if.req_ready}, 8'd0);
    chk("post rst busy", {7'b0, busy}, 8'd0);
    chk("post rst pwm_hi", p_hi, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
